// File: rtl/dot_product_seq.sv
// dot_product_seq
// Sequential fixed-point dot product of two SIZE-element vectors. It uses
// LANES multipliers per clock, so one vector pair takes SIZE/LANES MAC beats.
// The full-precision sum is shifted right by FRAC (floor) and saturated to
// WIDTH bits.
//
// Ports
//   CLK        rising-edge clock
//   RST_N      asynchronous active-low reset
//   a, b       packed input vectors; element i = [WIDTH*(i+1)-1 : WIDTH*i]
//   in_valid   a/b valid
//   in_ready   high only while idle; accept = in_valid && in_ready
//   y          saturated dot product, FRAC fractional bits
//   sat        y was clipped (qualified by out_valid)
//   out_valid  y/sat valid; held until out_ready
//   out_ready  consumer takes y
module dot_product_seq #(
   parameter int WIDTH = 32,
   parameter int SIZE  = 4,
   parameter int LANES = 2,
   parameter int FRAC  = 16
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic [WIDTH*SIZE-1:0] a,
   input  logic [WIDTH*SIZE-1:0] b,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [WIDTH-1:0]      y,
   output logic                  sat,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam int VW    = WIDTH * SIZE;
   localparam int BEATS = SIZE / LANES;
   localparam int KW    = $clog2(BEATS + 1);
   localparam int PW    = 2 * WIDTH;
   localparam int ACCW  = PW + $clog2(SIZE);
   localparam int SHIFT = WIDTH * LANES;

   localparam logic [KW-1:0] K_DONE = KW'(BEATS);
   localparam logic signed [ACCW-1:0] Y_MAX =
      {{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [ACCW-1:0] Y_MIN =
      {{(ACCW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MAC, RESULT} state_t;

   state_t                 state;
   state_t                 next_state;
   logic                   start;
   logic [KW-1:0]          k;
   logic [VW-1:0]          a_sh;
   logic [VW-1:0]          b_sh;
   logic signed [ACCW-1:0] acc;
   logic signed [ACCW-1:0] beat_sum;
   logic signed [ACCW-1:0] shifted;
   logic signed [PW-1:0]   prod [LANES];
   logic [WIDTH-1:0]       y_next;
   logic                   sat_next;

   // State register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic and handshake outputs. MAC stays one extra edge after
   // the last beat (k == K_DONE), and that edge registers the result.
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      start      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               start      = 1'b1;
               next_state = MAC;
            end
         end
         MAC: begin
            if (k == K_DONE) begin
               next_state = RESULT;
            end
         end
         RESULT: begin
            if (out_ready) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // The operand copies shift down by LANES elements on every beat. The
   // current beat's elements therefore always sit in the low LANES slots.
   // Operands are sign-extended to 2*WIDTH before multiplying, so every
   // product is exact.
   always_comb begin
      beat_sum = '0;
      for (int l = 0; l < LANES; l++) begin
         prod[l] = $signed({{WIDTH{a_sh[WIDTH*l+WIDTH-1]}}, a_sh[WIDTH*l +: WIDTH]})
                 * $signed({{WIDTH{b_sh[WIDTH*l+WIDTH-1]}}, b_sh[WIDTH*l +: WIDTH]});
         beat_sum = beat_sum + $signed({{(ACCW-PW){prod[l][PW-1]}}, prod[l]});
      end
   end

   // Floor-shift the accumulator back to FRAC fractional bits, then clip
   // the value to the signed WIDTH-bit range.
   always_comb begin
      shifted  = acc >>> FRAC;
      y_next   = shifted[WIDTH-1:0];
      sat_next = 1'b0;
      if (shifted > Y_MAX) begin
         y_next   = Y_MAX[WIDTH-1:0];
         sat_next = 1'b1;
      end else if (shifted < Y_MIN) begin
         y_next   = Y_MIN[WIDTH-1:0];
         sat_next = 1'b1;
      end
   end

   // Datapath: latch the operands on accept, accumulate one beat per edge,
   // register the saturated result, and drop out_valid once it is consumed.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         a_sh      <= '0;
         b_sh      <= '0;
         k         <= '0;
         acc       <= '0;
         y         <= '0;
         sat       <= 1'b0;
         out_valid <= 1'b0;
      end else if (start) begin
         a_sh <= a;
         b_sh <= b;
         k    <= '0;
         acc  <= '0;
      end else if (state == MAC) begin
         if (k != K_DONE) begin
            acc  <= acc + beat_sum;
            a_sh <= a_sh >> SHIFT;
            b_sh <= b_sh >> SHIFT;
            k    <= k + KW'(1);
         end else begin
            y         <= y_next;
            sat       <= sat_next;
            out_valid <= 1'b1;
         end
      end else if (state == RESULT && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
